// File: rtl/fifo_depth16.sv
// fifo_depth16: 16-entry synchronous FIFO, register storage, registered 16:1 mux read path.
// Define FIFO_ERR_FLAG_EN to add the sticky o_ovf / o_udf error flags.

module fifo_mux_16_1 #(
  parameter int W = 4
) (
  input  logic [16*W-1:0] din,
  input  logic [3:0]      sel,
  output logic [W-1:0]    dout
);

  always_comb begin
    dout = din[sel*W +: W];
  end

endmodule

module fifo_depth16 #(
  parameter int bw   = 4,
  parameter int simd = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic [simd*bw-1:0]   in,
  input  logic                 rd,
  output logic [simd*bw-1:0]   out,
  output logic                 o_full,
  output logic                 o_empty
`ifdef FIFO_ERR_FLAG_EN
  ,
  output logic                 o_ovf,
  output logic                 o_udf
`endif
);

  localparam int W = simd * bw;

  logic [15:0][W-1:0] mem;
  logic [4:0]         wr_ptr;
  logic [4:0]         rd_ptr;
  logic               push;
  logic               pop;
  logic [W-1:0]       rd_word;

  // Bit 4 of each pointer is the wrap bit that separates full from empty.
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[3:0] == rd_ptr[3:0]) && (wr_ptr[4] != rd_ptr[4]);

  assign push = wr && !o_full;
  assign pop  = rd && !o_empty;

  // Storage is never cleared; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr[3:0]] <= in;
    end
  end

  fifo_mux_16_1 #(.W(W)) u_rd_mux (
    .din  (mem),
    .sel  (rd_ptr[3:0]),
    .dout (rd_word)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= 5'd0;
      rd_ptr <= 5'd0;
      out    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 5'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 5'd1;
        out    <= rd_word;
      end
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_ovf <= 1'b0;
      o_udf <= 1'b0;
    end else begin
      if (wr && o_full) begin
        o_ovf <= 1'b1;
      end
      if (rd && o_empty) begin
        o_udf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_depth16.sv
// Self-checking bench for fifo_depth16 with a queue scoreboard as reference model.
// Error-flag checks are compiled in when FIFO_ERR_FLAG_EN is defined.

module tb_fifo_depth16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic [3:0] in;
  logic       rd;
  logic [3:0] out;
  logic       o_full;
  logic       o_empty;
`ifdef FIFO_ERR_FLAG_EN
  logic       o_ovf;
  logic       o_udf;
`endif

  int         n_cmp = 0;
  int         n_err = 0;

  logic [3:0] sb[$];
  logic [3:0] exp_out;
  logic       exp_ovf;
  logic       exp_udf;

  fifo_depth16 #(.bw(4), .simd(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .in      (in),
    .rd      (rd),
    .out     (out),
    .o_full  (o_full),
    .o_empty (o_empty)
`ifdef FIFO_ERR_FLAG_EN
    ,
    .o_ovf   (o_ovf),
    .o_udf   (o_udf)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, update the scoreboard, and return #1 after the edge.
  task automatic tick(input logic rst_n, input logic w, input logic [3:0] d, input logic r);
    int occ;
    reset = rst_n;
    wr    = w;
    in    = d;
    rd    = r;
    occ   = sb.size();
    if (!rst_n) begin
      sb.delete();
      exp_out = 4'h0;
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      if (w && occ == 16) exp_ovf = 1'b1;
      if (r && occ == 0)  exp_udf = 1'b1;
      if (r && occ != 0)  exp_out = sb.pop_front();
      if (w && occ != 16) sb.push_back(d);
    end
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 4'h0, 1'b0);
    tick(1'b0, 1'b0, 4'h0, 1'b0);
    n_cmp++;
    if ({o_full, o_empty} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_flags: full/empty got %b%b want 01", o_full, o_empty);
    end
    n_cmp++;
    if (out !== 4'h0) begin
      n_err++;
      $display("FAIL reset_out: got %h want 0", out);
    end
    reset = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      tick(1'b1, 1'b1, 4'(i), 1'b0);
      n_cmp++;
      if ({o_full, o_empty} !== {i == 16, 1'b0}) begin
        n_err++;
        $display("FAIL fill_flags[%0d]: full/empty got %b%b want %b0", i, o_full, o_empty, i == 16);
      end
    end
    for (int i = 1; i <= 16; i++) begin
      tick(1'b1, 1'b0, 4'h0, 1'b1);
      n_cmp++;
      if (out !== exp_out || exp_out !== 4'(i)) begin
        n_err++;
        $display("FAIL drain_out[%0d]: got %h want %h", i, out, 4'(i));
      end
      n_cmp++;
      if ({o_full, o_empty} !== {1'b0, i == 16}) begin
        n_err++;
        $display("FAIL drain_flags[%0d]: full/empty got %b%b want 0%b", i, o_full, o_empty, i == 16);
      end
    end
  endtask

  task automatic test_wrap();
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 10; i++) begin
        tick(1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'b0);
        n_cmp++;
        if ({o_full, o_empty} !== 2'b00) begin
          n_err++;
          $display("FAIL wrap_push_flags[%0d.%0d]: got %b%b want 00", rep, i, o_full, o_empty);
        end
      end
      for (int i = 0; i < 10; i++) begin
        tick(1'b1, 1'b0, 4'h0, 1'b1);
        n_cmp++;
        if (out !== exp_out) begin
          n_err++;
          $display("FAIL wrap_out[%0d.%0d]: got %h want %h", rep, i, out, exp_out);
        end
        n_cmp++;
        if ({o_full, o_empty} !== {1'b0, i == 9}) begin
          n_err++;
          $display("FAIL wrap_pop_flags[%0d.%0d]: got %b%b want 0%b", rep, i, o_full, o_empty, i == 9);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 4'(i + 3), 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'b1);
      n_cmp++;
      if (out !== exp_out || sb.size() != 5) begin
        n_err++;
        $display("FAIL simul_out[%0d]: got %h want %h (model occ %0d)", i, out, exp_out, sb.size());
      end
      n_cmp++;
      if ({o_full, o_empty} !== 2'b00) begin
        n_err++;
        $display("FAIL simul_flags[%0d]: got %b%b want 00", i, o_full, o_empty);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 4'h0, 1'b1);
      n_cmp++;
      if (out !== exp_out) begin
        n_err++;
        $display("FAIL simul_drain[%0d]: got %h want %h", i, out, exp_out);
      end
    end
    // Empty: only the write is taken, out keeps its value.
    tick(1'b1, 1'b1, 4'hC, 1'b1);
    n_cmp++;
    if (out !== exp_out || {o_full, o_empty} !== 2'b00) begin
      n_err++;
      $display("FAIL simul_empty: out %h flags %b%b want out %h flags 00", out, o_full, o_empty, exp_out);
    end
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b1, 4'(i), 1'b0);
    // Full: only the read is taken, the written word 0x5 is lost.
    tick(1'b1, 1'b1, 4'h5, 1'b1);
    n_cmp++;
    if (out !== 4'hC || {o_full, o_empty} !== 2'b00) begin
      n_err++;
      $display("FAIL simul_full: out %h flags %b%b want out c flags 00", out, o_full, o_empty);
    end
    for (int i = 0; i < 15; i++) begin
      tick(1'b1, 1'b0, 4'h0, 1'b1);
      n_cmp++;
      if (out !== exp_out || exp_out !== 4'(i)) begin
        n_err++;
        $display("FAIL simul_full_drain[%0d]: got %h want %h", i, out, 4'(i));
      end
    end
    n_cmp++;
    if ({o_full, o_empty} !== 2'b01) begin
      n_err++;
      $display("FAIL simul_end_flags: got %b%b want 01", o_full, o_empty);
    end
  endtask

`ifdef FIFO_ERR_FLAG_EN
  task automatic test_err_flags();
    tick(1'b1, 1'b0, 4'h0, 1'b1);
    n_cmp++;
    if ({o_ovf, o_udf} !== {exp_ovf, exp_udf} || o_udf !== 1'b1) begin
      n_err++;
      $display("FAIL err_udf: ovf/udf got %b%b want %b%b", o_ovf, o_udf, exp_ovf, exp_udf);
    end
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b1, 4'(15 - i), 1'b0);
    tick(1'b1, 1'b1, 4'h9, 1'b0);
    tick(1'b1, 1'b0, 4'h0, 1'b0);
    n_cmp++;
    if ({o_ovf, o_udf} !== 2'b11) begin
      n_err++;
      $display("FAIL err_ovf_sticky: ovf/udf got %b%b want 11", o_ovf, o_udf);
    end
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b0, 4'h0, 1'b1);
      n_cmp++;
      if (out !== exp_out || exp_out !== 4'(15 - i)) begin
        n_err++;
        $display("FAIL err_contents[%0d]: got %h want %h", i, out, 4'(15 - i));
      end
    end
    tick(1'b0, 1'b0, 4'h0, 1'b0);
    n_cmp++;
    if ({o_ovf, o_udf} !== 2'b00) begin
      n_err++;
      $display("FAIL err_reset_clear: ovf/udf got %b%b want 00", o_ovf, o_udf);
    end
  endtask
`endif

  task automatic test_midop_reset();
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 4'(i + 8), 1'b0);
    tick(1'b1, 1'b0, 4'h0, 1'b1);
    tick(1'b0, 1'b1, 4'h3, 1'b1);
    n_cmp++;
    if ({o_full, o_empty} !== 2'b01 || out !== 4'h0) begin
      n_err++;
      $display("FAIL midop_reset: flags %b%b out %h want flags 01 out 0", o_full, o_empty, out);
    end
    tick(1'b1, 1'b1, 4'hA, 1'b0);
    tick(1'b1, 1'b0, 4'h0, 1'b1);
    n_cmp++;
    if (out !== 4'hA || exp_out !== 4'hA) begin
      n_err++;
      $display("FAIL midop_push_pop: got %h want a", out);
    end
    n_cmp++;
    if ({o_full, o_empty} !== 2'b01) begin
      n_err++;
      $display("FAIL midop_end_flags: got %b%b want 01", o_full, o_empty);
    end
  endtask

  initial begin
    reset   = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    in      = 4'h0;
    exp_out = 4'h0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
`ifdef FIFO_ERR_FLAG_EN
    test_err_flags();
`endif
    test_midop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
